memory_access_ctrl: RTL and testbench
=====================================

MEMORY_ACCESS_CTRL -- requirements
Module: memory_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning memory address width (16 locations).
REQ-002 SHALL have parameter DATA_W, default 8, meaning memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents a command.
REQ-006 SHALL have port req_ready  output  1  controller accepts a command; high only in IDLE.
REQ-007 SHALL have port req_we  input  1  1 = single write, 0 = read burst.
REQ-008 SHALL have port req_addr  input  ADDR_W  start address.
REQ-009 SHALL have port req_len  input  4  read beats minus 1 (0..15); ignored for writes.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  response beat available.
REQ-012 SHALL have port rsp_ready  input  1  requester takes the beat.
REQ-013 SHALL have port rsp_data  output  DATA_W  read data; 0 on write acknowledge.
REQ-014 SHALL have port rsp_last  output  1  final beat of the command.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_address  output  ADDR_W  memory address.
REQ-017 SHALL have port mem_data_in  output  DATA_W  memory write data.
REQ-018 SHALL have port mem_data_out  input  DATA_W  memory read data, registered by the memory on the posedge where mem_we=0.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP; all outputs registered or decoded from state only.
REQ-020 SHALL accept a command on the posedge with req_valid && req_ready, latching we/addr/len/wdata and entering ISSUE.
REQ-021 SHALL, in ISSUE, drive mem_address = current address, mem_data_in = latched wdata, mem_we = 1 for writes, 0 for reads.
REQ-022 SHALL assert mem_we for exactly one cycle per write command and never otherwise.
REQ-023 SHALL, for writes, go ISSUE -> RESP with rsp_valid=1, rsp_last=1, rsp_data=0 (ack one cycle after acceptance).
REQ-024 SHALL, for reads, go ISSUE -> CAPTURE; at the end of CAPTURE, register rsp_data <= mem_data_out and enter RESP (data visible two cycles after acceptance, or after re-issue).
REQ-025 SHALL hold rsp_valid, rsp_data, rsp_last stable in RESP while rsp_ready=0; mem_we=0 during stall.
REQ-026 SHALL, on RESP && rsp_ready, go to IDLE if rsp_last, else increment address modulo 2^ADDR_W (15 -> 0) and go to ISSUE.
REQ-027 SHALL assert rsp_last on the beat where the beat counter equals latched len.
REQ-028 SHALL ignore req_valid outside IDLE; req_ready returns high the cycle after the last beat is taken.
REQ-029 SHALL keep rsp_valid low in IDLE, ISSUE and CAPTURE.

Reset
REQ-030 SHALL, on rst=1 at a posedge, enter IDLE and set req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, mem_we=0, mem_address=0, mem_data_in=0, beat counter=0.
REQ-031 SHALL abort any burst or pending response on mid-operation reset with no further memory write; rst has priority over all handshakes.

Verification
REQ-032 SHALL cover: write addr 3 data 0xA5 -> mem_we high exactly one cycle with mem_address=3, ack rsp_valid next cycle, rsp_data=0, rsp_last=1.
REQ-033 SHALL cover: read addr 3 len 0 after scenario 1 -> rsp_data=0xA5, rsp_last=1, rsp_valid two cycles after acceptance.
REQ-034 SHALL cover: memory preloaded mem[i]=i+0x10, read addr 14 len 3 -> beats 0x1E,0x1F,0x10,0x11 (wrap 15->0), rsp_last on fourth only.
REQ-035 SHALL cover: rsp_ready held low 5 cycles during a read beat -> rsp_data/rsp_valid stable, no mem_we, no address advance.
REQ-036 SHALL cover: req_valid held high during a burst with different addr -> ignored; req_ready=0 until final beat taken.
REQ-037 SHALL cover: rst asserted mid-burst (beat 2 of 8) -> next cycle IDLE, rsp_valid=0, mem_we=0, req_ready=1, next command executes normally.

Source files
------------

// File: rtl/memory_access_ctrl.sv
// Memory access controller: accepts single-word writes and read bursts of
// up to 16 beats, sequences them onto a synchronous single-port memory and
// returns one response beat per word through a valid/ready handshake.
module memory_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [3:0]          len_reg;
    logic [3:0]          beat_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                last_beat;

    // Writes always carry len 0, so the final-beat compare covers both kinds.
    assign last_beat = (beat_reg == len_reg);

    // Next-state decode; the handshake inputs only matter in IDLE and RESP.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   state_next = we_reg ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = last_beat ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath registers; reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            len_reg      <= '0;
            beat_reg     <= '0;
            wdata_reg    <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        addr_reg  <= req_addr;
                        len_reg   <= req_we ? 4'd0 : req_len;
                        wdata_reg <= req_wdata;
                        beat_reg  <= '0;
                    end
                end
                ISSUE: begin
                    // Write acknowledge carries zero data.
                    if (we_reg) rsp_data_reg <= '0;
                end
                CAPTURE: begin
                    // Memory registered the word on the ISSUE edge.
                    rsp_data_reg <= mem_data_out;
                end
                RESP: begin
                    if (rsp_ready && !last_beat) begin
                        addr_reg <= addr_reg + 1'b1;
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state or taken straight from registers.
    assign req_ready   = (state_reg == IDLE);
    assign rsp_valid   = (state_reg == RESP);
    assign rsp_last    = (state_reg == RESP) && last_beat;
    assign rsp_data    = rsp_data_reg;
    assign mem_we      = (state_reg == ISSUE) && we_reg;
    assign mem_address = addr_reg;
    assign mem_data_in = wdata_reg;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Bench for memory_access_ctrl: table of commands driven through a task,
// expected response beats queued from a shadow memory model and compared as
// the controller presents them, plus a hand-written mid-burst reset.
module tb_memory_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [3:0] req_addr, req_len;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_last;
    logic [7:0] rsp_data;
    logic       mem_we;
    logic [3:0] mem_address;
    logic [7:0] mem_data_in, mem_data_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [3:0] len;
        logic [7:0] wdata;
        int         stall_beat;
        int         stall_cyc;
        bit         hold_valid;
        logic [7:0] exp_first;
    } vec_t;
    vec_t vecs[8];

    logic [7:0] mem[16];
    logic [7:0] ref_mem[16];
    logic       preload;

    always #5 clk = ~clk;

    // Synchronous memory: write on mem_we, otherwise register the read word.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 16);
        end else if (mem_we) begin
            mem[mem_address] <= mem_data_in;
        end else begin
            mem_data_out <= mem[mem_address];
        end
    end

    memory_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .mem_we(mem_we), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Issue one command and walk its response beats. abort_beat >= 0 resets
    // the DUT when that beat is presented instead of taking it.
    task automatic run_cmd(input logic we, input logic [3:0] addr, input logic [3:0] len,
                           input logic [7:0] wd, input int stall_beat, input int stall_cyc,
                           input bit hold_valid, input int abort_beat, input logic [7:0] exp_first);
        int         nbeats;
        int         n;
        exp_t       e;
        logic [7:0] hd;
        logic [3:0] ha;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wd;
        nbeats = we ? 1 : int'(len) + 1;
        for (int i = 0; i < nbeats; i++) begin
            e.data = we ? 8'h00 : ref_mem[4'(int'(addr) + i)];
            e.last = (i == nbeats - 1);
            exp_q.push_back(e);
        end
        if (we) ref_mem[addr] = wd;
        @(negedge clk);
        if (hold_valid) begin
            req_we = 1'b1; req_addr = addr ^ 4'h8; req_wdata = 8'hEE;
        end else begin
            req_valid = 1'b0;
        end
        chk("mem_we_issue", mem_we, we);
        chk("mem_addr_issue", mem_address, addr);
        if (we) chk("mem_data_in_issue", mem_data_in, wd);
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            while (!rsp_valid && n < 8) begin
                if (!we) chk("mem_we_read", mem_we, 0);
                if (hold_valid) chk("req_ready_busy", req_ready, 0);
                @(negedge clk);
                n++;
            end
            if (!rsp_valid) begin
                chk("rsp_timeout", 0, 1);
                exp_q.delete();
                req_valid = 1'b0;
                return;
            end
            chk("beat_latency", n, (we && b == 0) ? 1 : 2);
            if (b == abort_beat) begin
                rst = 1'b1; rsp_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0; rsp_ready = 1'b0;
                chk("abort_rsp_valid", rsp_valid, 0);
                chk("abort_rsp_last", rsp_last, 0);
                chk("abort_mem_we", mem_we, 0);
                chk("abort_req_ready", req_ready, 1);
                chk("abort_mem_addr", mem_address, 0);
                @(negedge clk);
                chk("abort_mem_we_later", mem_we, 0);
                exp_q.delete();
                $display("[TB] cmd we=%0d addr=%0d len=%0d aborted at beat %0d", we, addr, len, b);
                return;
            end
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_last", rsp_last, e.last);
            if (b == 0) chk("rsp_first_table", rsp_data, exp_first);
            if (b == stall_beat) begin
                hd = rsp_data; ha = mem_address;
                repeat (stall_cyc) begin
                    @(negedge clk);
                    chk("stall_valid", rsp_valid, 1);
                    chk("stall_data", rsp_data, hd);
                    chk("stall_last", rsp_last, e.last);
                    chk("stall_mem_we", mem_we, 0);
                    chk("stall_addr", mem_address, ha);
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        chk("req_ready_after", req_ready, 1);
        req_valid = 1'b0;
        $display("[TB] cmd we=%0d addr=%0d len=%0d wdata=0x%02h done, first=0x%02h",
                 we, addr, len, wd, exp_first);
    endtask

    initial begin
        // we addr len wdata stall_beat stall_cyc hold_valid exp_first
        vecs[0] = '{1'b1, 4'd3,  4'd0,  8'hA5, -1, 0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 4'd3,  4'd0,  8'h00, -1, 0, 1'b0, 8'hA5};
        vecs[2] = '{1'b0, 4'd14, 4'd3,  8'h00, -1, 0, 1'b0, 8'h1E};
        vecs[3] = '{1'b0, 4'd5,  4'd2,  8'h00,  1, 5, 1'b0, 8'h15};
        vecs[4] = '{1'b0, 4'd2,  4'd4,  8'h00, -1, 0, 1'b1, 8'h12};
        vecs[5] = '{1'b1, 4'd15, 4'd0,  8'h3C, -1, 0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 4'd15, 4'd1,  8'h00, -1, 0, 1'b0, 8'h3C};
        vecs[7] = '{1'b0, 4'd0,  4'd15, 8'h00,  0, 2, 1'b0, 8'h10};

        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i + 16);
        repeat (3) @(negedge clk);
        preload = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++)
            run_cmd(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].wdata, vecs[v].stall_beat,
                    vecs[v].stall_cyc, vecs[v].hold_valid, -1, vecs[v].exp_first);

        // Mid-burst reset on beat 2 of an 8-beat read, then normal traffic.
        run_cmd(1'b0, 4'd4, 4'd7, 8'h00, -1, 0, 1'b0, 2, 8'h14);
        run_cmd(1'b1, 4'd7, 4'd0, 8'h77, -1, 0, 1'b0, -1, 8'h00);
        run_cmd(1'b0, 4'd6, 4'd2, 8'h00, -1, 0, 1'b0, -1, 8'h16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
